// File: rtl/sigmoid_pkg.sv
// Shared types, constants and helpers for the bfloat16 sigmoid pipeline.
package sigmoid_pkg;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] mant;
   } bf16_t;

   typedef enum logic [2:0] {
      CLS_NORMAL,
      CLS_ZERO,
      CLS_POS_INF,
      CLS_NEG_INF,
      CLS_NAN
   } op_class_e;

   localparam int unsigned LATENCY = 4;

   localparam logic [15:0] BF16_ZERO = 16'h0000;
   localparam logic [15:0] BF16_ONE  = 16'h3F80;
   localparam logic [15:0] BF16_HALF = 16'h3F00;
   localparam logic [15:0] BF16_QNAN = 16'h7FC0;

   // |x| is Q4.16, y is Q1.16
   localparam int unsigned FIX_INT_W  = 4;
   localparam int unsigned FIX_FRAC_W = 16;
   localparam int unsigned FIX_W      = FIX_INT_W + FIX_FRAC_W;
   localparam int unsigned Y_W        = 1 + FIX_FRAC_W;

   localparam logic [7:0] EXP_SPECIAL = 8'hFF;
   localparam logic [7:0] EXP_SAT     = 8'd130;
   localparam logic [7:0] EXP_MIN     = 8'd111;
   // Exponent at which {1,mant} lands in Q4.16 without shifting
   localparam logic [7:0] EXP_ALIGN   = 8'd118;
   // bf16 exponent of the Q1.16 LSB (bias minus fraction width)
   localparam logic [7:0] EXP_Y_LSB   = 8'd111;

   localparam logic [FIX_W-1:0] ABS_SAT   = 20'h80000;
   localparam logic [FIX_W-1:0] BRK_5P0   = 20'h50000;
   localparam logic [FIX_W-1:0] BRK_2P375 = 20'h26000;
   localparam logic [FIX_W-1:0] BRK_1P0   = 20'h10000;

   localparam logic [Y_W-1:0] Y_ONE       = 17'h10000;
   localparam logic [Y_W-1:0] OFF_0P84375 = 17'h0D800;
   localparam logic [Y_W-1:0] OFF_0P625   = 17'h0A000;
   localparam logic [Y_W-1:0] OFF_0P5     = 17'h08000;

   function automatic op_class_e classify(input bf16_t x);
      if (x.exp == EXP_SPECIAL) begin
         if (x.mant != '0) classify = CLS_NAN;
         else              classify = x.sign ? CLS_NEG_INF : CLS_POS_INF;
      end else if (x.exp == '0) begin
         classify = CLS_ZERO;
      end else begin
         classify = CLS_NORMAL;
      end
   endfunction

   function automatic logic [FIX_W-1:0] to_fixed(input bf16_t x);
      logic [FIX_W-1:0] sig;
      sig = FIX_W'({1'b1, x.mant});
      if (x.exp >= EXP_SAT)        to_fixed = ABS_SAT;
      else if (x.exp < EXP_MIN)    to_fixed = '0;
      else if (x.exp >= EXP_ALIGN) to_fixed = sig << (x.exp - EXP_ALIGN);
      else                         to_fixed = sig >> (EXP_ALIGN - x.exp);
   endfunction

   function automatic logic [Y_W-1:0] eval_segment(input logic [FIX_W-1:0] a);
      if (a >= BRK_5P0)        eval_segment = Y_ONE;
      else if (a >= BRK_2P375) eval_segment = Y_W'(a >> 5) + OFF_0P84375;
      else if (a >= BRK_1P0)   eval_segment = Y_W'(a >> 3) + OFF_0P625;
      else                     eval_segment = Y_W'(a >> 2) + OFF_0P5;
   endfunction

endpackage

// File: rtl/sigmoid_pipelined_fixed_to_bf16.sv
// Combinational Q1.16 -> bf16 normalizer (stage 4 of sigmoid_pipelined).
// Truncates by default; define SIGMOID_RNE_EN for round-to-nearest-even.
module fixed_to_bf16
   import sigmoid_pkg::*;
(
   input  logic [Y_W-1:0] y,
   output logic [15:0]    bf
);

   logic [4:0]     lead;
   logic [Y_W-1:0] norm;
   logic [7:0]     exp_f;
   logic [6:0]     mant;
   bf16_t          res;
`ifdef SIGMOID_RNE_EN
   logic           guard;
   logic           sticky;
   logic [7:0]     mant_inc;
`endif

   always_comb begin
      lead = '0;
      for (int unsigned i = 0; i < Y_W; i++) begin
         if (y[i]) lead = 5'(i);
      end
      norm  = y << (5'(Y_W - 1) - lead);
      exp_f = EXP_Y_LSB + {3'b000, lead};
      mant  = 7'(norm >> (Y_W - 8));
`ifdef SIGMOID_RNE_EN
      guard    = norm[Y_W-9];
      sticky   = |norm[Y_W-10:0];
      mant_inc = {1'b0, mant} + 8'd1;
      if (guard && (sticky || mant[0])) begin
         mant = mant_inc[6:0];
         if (mant_inc[7]) exp_f = exp_f + 8'd1;
      end
`endif
      res.sign = 1'b0;
      res.exp  = exp_f;
      res.mant = mant;
      // No leading one after normalizing means y was zero
      if (!norm[Y_W-1]) res = '0;
      bf = res;
   end

endmodule

// File: rtl/sigmoid_pipelined.sv
// Four-stage bfloat16 sigmoid approximation (piecewise-linear, shift/add only).
// Optional macro SIGMOID_RNE_EN selects round-to-nearest-even in the normalizer.
module sigmoid_pipelined
   import sigmoid_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [15:0] data_in,
   output logic        valid_out,
   output logic [15:0] data_out
);

   bf16_t x;
   assign x = data_in;

   logic             s1_valid, s1_neg;
   op_class_e        s1_cls;
   logic [FIX_W-1:0] s1_abs;

   logic             s2_valid, s2_neg;
   op_class_e        s2_cls;
   logic [Y_W-1:0]   s2_y;

   logic             s3_valid;
   op_class_e        s3_cls;
   logic [Y_W-1:0]   s3_y;

   logic [15:0]      y_bf;
   logic [15:0]      result;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_neg   <= 1'b0;
         s1_cls   <= CLS_NORMAL;
         s1_abs   <= '0;
      end else begin
         s1_valid <= valid_in;
         if (valid_in) begin
            s1_neg <= x.sign;
            s1_cls <= classify(x);
            s1_abs <= to_fixed(x);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_neg   <= 1'b0;
         s2_cls   <= CLS_NORMAL;
         s2_y     <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_neg <= s1_neg;
            s2_cls <= s1_cls;
            s2_y   <= eval_segment(s1_abs);
         end
      end
   end

   // sigmoid(-x) = 1 - sigmoid(x)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s3_valid <= 1'b0;
         s3_cls   <= CLS_NORMAL;
         s3_y     <= '0;
      end else begin
         s3_valid <= s2_valid;
         if (s2_valid) begin
            s3_cls <= s2_cls;
            s3_y   <= s2_neg ? (Y_ONE - s2_y) : s2_y;
         end
      end
   end

   fixed_to_bf16 u_norm (
      .y  (s3_y),
      .bf (y_bf)
   );

   always_comb begin
      result = y_bf;
      unique case (s3_cls)
         CLS_ZERO:    result = BF16_HALF;
         CLS_POS_INF: result = BF16_ONE;
         CLS_NEG_INF: result = BF16_ZERO;
         CLS_NAN:     result = BF16_QNAN;
         default:     result = y_bf;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_out <= 1'b0;
         data_out  <= '0;
      end else begin
         valid_out <= s3_valid;
         if (s3_valid) data_out <= result;
      end
   end

endmodule

// File: tb/tb_sigmoid_pipelined.sv
// Self-checking bench for sigmoid_pipelined: directed vectors, random traffic,
// reset-in-flight and a full 16-bit sweep against a real-arithmetic model.
module tb_sigmoid_pipelined;
   import sigmoid_pkg::*;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic [15:0] data_in;
   logic        valid_out;
   logic [15:0] data_out;

   sigmoid_pipelined dut (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (valid_in),
      .data_in   (data_in),
      .valid_out (valid_out),
      .data_out  (data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] expv;
      int unsigned due;
   } sb_t;

   sb_t         sb[$];
   int unsigned cyc = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;
   logic [15:0] last_out = '0;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, expv, cyc);
      end
   endtask

   function automatic logic [15:0] ref_sigmoid(input logic [15:0] op);
      int    e = int'(op[14:7]);
      int    m = int'(op[6:0]);
      longint a;
      longint y;
      real   v;
      real   frac;
      int    ex;
      int    mant;
      if (e == 255) return (m != 0) ? 16'h7FC0 : (op[15] ? 16'h0000 : 16'h3F80);
      if (e == 0) return 16'h3F00;
      // |x| = 1.m * 2^(e-127), expressed in units of 2^-16 and truncated
      if (e >= 130) a = 8 * 65536;
      else if (e < 111) a = 0;
      else begin
         v = real'(128 + m);
         if (e >= 118) for (int k = 0; k < e - 118; k++) v = v * 2.0;
         else          for (int k = 0; k < 118 - e; k++) v = v / 2.0;
         a = longint'($floor(v));
      end
      if (a >= 5 * 65536)                      y = 65536;
      else if (real'(a) >= 2.375 * 65536.0)    y = a / 32 + longint'(0.84375 * 65536.0);
      else if (a >= 65536)                     y = a / 8 + longint'(0.625 * 65536.0);
      else                                     y = a / 4 + longint'(0.5 * 65536.0);
      if (op[15]) y = 65536 - y;
      if (y == 0) return 16'h0000;
      v  = real'(y) / 65536.0;
      ex = 0;
      while (v >= 2.0) begin v = v / 2.0; ex++; end
      while (v < 1.0)  begin v = v * 2.0; ex--; end
      frac = (v - 1.0) * 128.0;
      mant = int'($floor(frac));
`ifdef SIGMOID_RNE_EN
      if ((frac - real'(mant)) > 0.5 || ((frac - real'(mant)) == 0.5 && (mant % 2) == 1))
         mant++;
      if (mant == 128) begin mant = 0; ex++; end
`endif
      return {1'b0, 8'(127 + ex), 7'(mant)};
   endfunction

   // Passive monitor: every cycle out of reset either a result is due or the output holds
   always @(posedge clk) begin
      cyc++;
      #1;
      if (rst) begin
         last_out = '0;
      end else if (sb.size() > 0 && sb[0].due == cyc) begin
         check("valid_out", 16'(valid_out), 16'h0001);
         check("data_out", data_out, sb[0].expv);
         last_out = sb[0].expv;
         void'(sb.pop_front());
      end else begin
         check("idle_valid", 16'(valid_out), 16'h0000);
         check("hold_data", data_out, last_out);
      end
   end

   task automatic send(input logic [15:0] op, input logic [15:0] expv);
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = op;
      sb.push_back('{expv, cyc + LATENCY});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         valid_in = 1'b0;
      end
   endtask

   logic [15:0] dir_in  [17] = '{16'h0000, 16'h3F80, 16'hBF80, 16'h3F00,
                                 16'h4000, 16'h4040, 16'h4080, 16'hC080,
                                 16'h40C0, 16'hC0C0, 16'h7F80, 16'hFF80, 16'h7FC1,
                                 16'h8000, 16'h0001, 16'h8040, 16'hFFC0};
   logic [15:0] dir_exp [17] = '{16'h3F00, 16'h3F40, 16'h3E80, 16'h3F20,
                                 16'h3F60, 16'h3F70, 16'h3F78, 16'h3D00,
                                 16'h3F80, 16'h0000, 16'h3F80, 16'h0000, 16'h7FC0,
                                 16'h3F00, 16'h3F00, 16'h3F00, 16'h7FC0};

   initial begin
      logic [15:0] op;
      rst      = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      repeat (5) @(posedge clk);
      #1;
      check("reset_valid", 16'(valid_out), 16'h0000);
      check("reset_data", data_out, 16'h0000);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors with constant expectations, streamed then spaced
      for (int i = 0; i < 17; i++) send(dir_in[i], dir_exp[i]);
      idle(6);
      for (int i = 0; i < 17; i++) begin
         send(dir_in[i], dir_exp[i]);
         idle(2);
      end
      idle(6);

      // Eight back-to-back distinct operands
      for (int i = 0; i < 8; i++) begin
         op = 16'h3C00 + 16'(i * 16'h0110);
         send(op, ref_sigmoid(op));
      end
      idle(6);

      // Random traffic biased toward the interesting exponent range, with gaps
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 1) == 0) op = 16'($urandom_range(0, 65535));
         else op = {1'($urandom), 8'($urandom_range(105, 135)), 7'($urandom)};
         send(op, ref_sigmoid(op));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      idle(6);

      // Reset with three samples in flight
      send(16'h3F80, 16'h3F40);
      idle(6);
      send(16'h4000, 16'h3F60);
      send(16'h4040, 16'h3F70);
      send(16'h4080, 16'h3F78);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async_valid", 16'(valid_out), 16'h0000);
      check("rst_async_data", data_out, 16'h0000);
      sb.delete();
      valid_in = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(8);
      send(16'hBF80, 16'h3E80);
      idle(6);

      // Exhaustive sweep, back-to-back
      for (int i = 0; i < 65536; i++) begin
         op = 16'(i);
         send(op, ref_sigmoid(op));
      end
      idle(8);
      check("drain", 16'(sb.size()), 16'h0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
